// File: rtl/savestates_reg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : savestates_pkg
// Brief   : Shared types and the shadowed-register address table.
// Revision: 1.0 - initial release
// ============================================================================
package savestates_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_MEMW    = 3'd4,
        ST_MEMR    = 3'd5,
        ST_NEXT    = 3'd6,
        ST_FIN     = 3'd7
    } ss_state_e;

    localparam int SS_REG_COUNT = 27;
    localparam int SS_IDX_W     = 5;

    // Low 16 bits of the CPU address; the bank byte is supplied by the sequencer
    localparam logic [15:0] SS_REG_ADDR [0:SS_REG_COUNT-1] = '{
        16'h4300, 16'h4301, 16'h4302, 16'h4303, 16'h4304, 16'h4305, 16'h4306,
        16'h4200,
        16'h4202, 16'h4203, 16'h4204, 16'h4205, 16'h4206, 16'h4207, 16'h4208,
        16'h4209, 16'h420A,
        16'h420C, 16'h420D, 16'h420F,
        16'h2100,
        16'h2181, 16'h2182, 16'h2183,
        16'h21F0, 16'h21F1, 16'h21F2
    };

endpackage
`default_nettype wire

// File: rtl/savestates_reg_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : savestates_reg_seq_if
// Brief   : Control, CPU register bus and save-state buffer signals.
// Revision: 1.0 - initial release
// ============================================================================
interface savestates_reg_seq_if;
    logic        start_save;
    logic        start_load;
    logic        busy;
    logic        done;
    logic        err;
    logic        ss_reg_sel;
    logic [23:0] ca;
    logic        cpurd_ce;
    logic        cpuwr_ce;
    logic [7:0]  dout;
    logic [7:0]  ssr_do;
    logic        ssr_oe;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        input  start_save, start_load, ssr_do, ssr_oe, mem_rdata, mem_ack,
        output busy, done, err, ss_reg_sel, ca, cpurd_ce, cpuwr_ce, dout,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start_save, start_load, ssr_do, ssr_oe, mem_rdata, mem_ack,
        input  busy, done, err, ss_reg_sel, ca, cpurd_ce, cpuwr_ce, dout,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/savestates_reg_seq_rom.sv
`default_nettype none
// ============================================================================
// Module  : savestates_reg_rom
// Brief   : Combinational table index to register address lookup.
// Revision: 1.0 - initial release
// ============================================================================
module savestates_reg_rom
    import savestates_pkg::*;
(
    input  logic [SS_IDX_W-1:0] i_idx,
    output logic [15:0]         o_addr
);

    // Out-of-range indices read as zero
    always_comb begin
        o_addr = 16'h0000;
        for (int i = 0; i < SS_REG_COUNT; i++) begin
            if (i_idx == SS_IDX_W'(i)) begin
                o_addr = SS_REG_ADDR[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/savestates_reg_seq.sv
`default_nettype none
// ============================================================================
// Module  : savestates_reg_seq
// Brief   : Bus-master sequencer moving shadowed registers to/from the buffer.
// Revision: 1.0 - initial release
// ============================================================================
module savestates_reg_seq
    import savestates_pkg::*;
#(
    parameter logic [7:0]  SS_BANK     = 8'hC0,
    parameter logic [7:0]  MEM_BASE    = 8'h00,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    savestates_reg_seq_if.master bus
);

    localparam int unsigned          c_TMO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0]   c_TMO_LAST = c_TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [SS_IDX_W-1:0]  c_IDX_LAST = SS_IDX_W'(SS_REG_COUNT - 1);

    ss_state_e             r_state, w_state_nxt;
    logic [SS_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic                  r_is_load, w_is_load_nxt;
    logic [c_TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic                  r_err, w_err_nxt;
    logic [7:0]            r_dout, w_dout_nxt;
    logic [7:0]            r_wdata, w_wdata_nxt;
    logic                  r_busy, r_done, r_sel, r_rd, r_wr, r_req, r_we;
    logic [23:0]           r_ca, w_ca_nxt;
    logic [7:0]            r_addr, w_addr_nxt;
    logic [15:0]           w_rom_addr;

    savestates_reg_rom u_rom (
        .i_idx  (w_idx_nxt),
        .o_addr (w_rom_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_is_load_nxt = r_is_load;
        w_tmo_nxt     = r_tmo;
        w_err_nxt     = r_err;
        w_dout_nxt    = r_dout;
        w_wdata_nxt   = r_wdata;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_save) begin
                    w_state_nxt   = ST_SETUP;
                    w_is_load_nxt = 1'b0;
                    w_idx_nxt     = '0;
                    w_err_nxt     = 1'b0;
                end else if (bus.start_load) begin
                    w_state_nxt   = ST_MEMR;
                    w_is_load_nxt = 1'b1;
                    w_idx_nxt     = '0;
                    w_err_nxt     = 1'b0;
                end
            end
            ST_SETUP:   w_state_nxt = ST_STROBE;
            ST_STROBE:  w_state_nxt = r_is_load ? ST_NEXT : ST_CAPTURE;
            ST_CAPTURE: begin
                // An unclaimed address stores all-ones and flags the save as suspect
                w_state_nxt = ST_MEMW;
                w_wdata_nxt = bus.ssr_oe ? bus.ssr_do : 8'hFF;
                if (!bus.ssr_oe) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_MEMW, ST_MEMR: begin
                if (bus.mem_ack) begin
                    w_state_nxt = (r_state == ST_MEMW) ? ST_NEXT : ST_SETUP;
                    if (r_state == ST_MEMR) begin
                        w_dout_nxt = bus.mem_rdata;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt = ST_FIN;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            ST_NEXT: begin
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_idx_nxt   = r_idx + 1'b1;
                    w_state_nxt = r_is_load ? ST_MEMR : ST_SETUP;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase

        // The ack wait counter restarts on every state entry
        if (w_state_nxt != r_state) begin
            w_tmo_nxt = '0;
        end

        w_ca_nxt   = (w_state_nxt == ST_SETUP) ? {SS_BANK, w_rom_addr} : r_ca;
        w_addr_nxt = (w_state_nxt inside {ST_MEMW, ST_MEMR}) ?
                     (MEM_BASE + {{(8 - SS_IDX_W){1'b0}}, w_idx_nxt}) : r_addr;
    end

    // Every output is registered from the next-state decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_is_load <= 1'b0;
            r_tmo     <= '0;
            r_err     <= 1'b0;
            r_dout    <= 8'h00;
            r_wdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sel     <= 1'b0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_ca      <= 24'h000000;
            r_addr    <= MEM_BASE;
        end else begin
            r_idx     <= w_idx_nxt;
            r_is_load <= w_is_load_nxt;
            r_tmo     <= w_tmo_nxt;
            r_err     <= w_err_nxt;
            r_dout    <= w_dout_nxt;
            r_wdata   <= w_wdata_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FIN);
            r_done    <= (w_state_nxt == ST_FIN);
            r_sel     <= (w_state_nxt inside {ST_SETUP, ST_STROBE, ST_CAPTURE});
            r_rd      <= (w_state_nxt == ST_STROBE) && !w_is_load_nxt;
            r_wr      <= (w_state_nxt == ST_STROBE) && w_is_load_nxt;
            r_req     <= (w_state_nxt inside {ST_MEMW, ST_MEMR});
            r_we      <= (w_state_nxt == ST_MEMW);
            r_ca      <= w_ca_nxt;
            r_addr    <= w_addr_nxt;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.ss_reg_sel = r_sel;
    assign bus.ca         = r_ca;
    assign bus.cpurd_ce   = r_rd;
    assign bus.cpuwr_ce   = r_wr;
    assign bus.dout       = r_dout;
    assign bus.mem_req    = r_req;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_savestates_reg_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_savestates_reg_seq
// Brief   : Scoreboard bench with responder and buffer models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_savestates_reg_seq;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    savestates_reg_seq_if bus_if ();

    savestates_reg_seq #(
        .SS_BANK     (8'hC0),
        .MEM_BASE    (8'h00),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    logic [15:0] tb_addr [27] = '{
        16'h4300, 16'h4301, 16'h4302, 16'h4303, 16'h4304, 16'h4305, 16'h4306,
        16'h4200, 16'h4202, 16'h4203, 16'h4204, 16'h4205, 16'h4206, 16'h4207,
        16'h4208, 16'h4209, 16'h420A, 16'h420C, 16'h420D, 16'h420F, 16'h2100,
        16'h2181, 16'h2182, 16'h2183, 16'h21F0, 16'h21F1, 16'h21F2
    };

    logic [7:0]  buffer [256];
    logic [15:0] oe_kill = 16'h0000;
    logic        ack_en = 1'b1;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    logic [15:0] exp_mw [$];
    logic [31:0] exp_cw [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_val(input logic [15:0] a);
        if (a == 16'h4202) return 8'h5A;
        if (a == 16'h2181) return 8'h34;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Shadow-register responder: registers read data from the address
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_if.ssr_do <= 8'h00;
            bus_if.ssr_oe <= 1'b0;
        end else begin
            bus_if.ssr_oe <= bus_if.ss_reg_sel && (bus_if.ca[23:16] == 8'hC0) &&
                             (bus_if.ca[15:0] != oe_kill);
            bus_if.ssr_do <= reg_val(bus_if.ca[15:0]);
        end
    end

    always @(posedge clk) begin
        if (!bus_if.mem_req || bus_if.mem_ack) ack_cnt <= 0;
        else ack_cnt <= ack_cnt + 1;
    end
    always_comb bus_if.mem_ack = ack_en && bus_if.mem_req && (ack_cnt >= ack_delay);
    always_comb bus_if.mem_rdata = buffer[bus_if.mem_addr];

    // Per-run monitor statistics, reset when busy rises
    int          busy_cyc, done_cyc, req_cyc, n_rd, n_wr, n_420c;
    logic        done_seen = 1'b0, req_seen, req_we, busy_at_done, err_at_done;
    logic [7:0]  dout_420c;
    logic [23:0] first_ca;
    logic        prev_busy = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0, prev_req = 1'b0;
    logic [7:0]  prev_addr = 8'h00, prev_wdata = 8'h00;

    always @(negedge clk) begin
        logic [15:0] em;
        logic [31:0] ec;
        if (bus_if.busy && !prev_busy) begin
            busy_cyc = cyc; done_seen = 1'b0; req_seen = 1'b0;
            n_rd = 0; n_wr = 0; n_420c = 0; first_ca = bus_if.ca;
        end
        if (bus_if.cpurd_ce) begin
            n_rd++;
            check_val("rd_one_cycle", prev_rd, 0);
            check_val("rd_sel", bus_if.ss_reg_sel, 1);
        end
        if (bus_if.cpuwr_ce) begin
            n_wr++;
            check_val("wr_one_cycle", prev_wr, 0);
            if (bus_if.ca == 24'hC0420C) begin
                n_420c++;
                dout_420c = bus_if.dout;
            end
            check_val("cw_expected", exp_cw.size() != 0, 1);
            if (exp_cw.size() != 0) begin
                ec = exp_cw.pop_front();
                check_val("cw_ca", bus_if.ca, ec[31:8]);
                check_val("cw_dout", bus_if.dout, ec[7:0]);
            end
        end
        if (bus_if.mem_req && !req_seen) begin
            req_seen = 1'b1; req_cyc = cyc; req_we = bus_if.mem_we;
        end
        if (bus_if.mem_req && prev_req) begin
            check_val("mem_addr_hold", bus_if.mem_addr, prev_addr);
            check_val("mem_wdata_hold", bus_if.mem_wdata, prev_wdata);
        end
        if (bus_if.mem_req && bus_if.mem_ack && bus_if.mem_we) begin
            buffer[bus_if.mem_addr] = bus_if.mem_wdata;
            check_val("mw_expected", exp_mw.size() != 0, 1);
            if (exp_mw.size() != 0) begin
                em = exp_mw.pop_front();
                check_val("mw_addr", bus_if.mem_addr, em[15:8]);
                check_val("mw_data", bus_if.mem_wdata, em[7:0]);
            end
        end
        if (bus_if.done) begin
            done_seen = 1'b1; done_cyc = cyc;
            busy_at_done = bus_if.busy; err_at_done = bus_if.err;
        end
        prev_busy = bus_if.busy; prev_rd = bus_if.cpurd_ce; prev_wr = bus_if.cpuwr_ce;
        prev_req = bus_if.mem_req; prev_addr = bus_if.mem_addr; prev_wdata = bus_if.mem_wdata;
    end

    task automatic pulse_start(input logic s, input logic l);
        @(negedge clk);
        bus_if.start_save = s;
        bus_if.start_load = l;
        @(negedge clk);
        bus_if.start_save = 1'b0;
        bus_if.start_load = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (done_seen) break;
        end
        check_val({tag, "_done_seen"}, done_seen, 1);
    endtask

    task automatic push_save_exp();
        for (int i = 0; i < 27; i++) begin
            exp_mw.push_back({i[7:0], (tb_addr[i] == oe_kill) ? 8'hFF : reg_val(tb_addr[i])});
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_busy"}, bus_if.busy, 0);
        check_val({tag, "_done"}, bus_if.done, 0);
        check_val({tag, "_err"}, bus_if.err, 0);
        check_val({tag, "_sel"}, bus_if.ss_reg_sel, 0);
        check_val({tag, "_ca"}, bus_if.ca, 0);
        check_val({tag, "_rd"}, bus_if.cpurd_ce, 0);
        check_val({tag, "_wr"}, bus_if.cpuwr_ce, 0);
        check_val({tag, "_dout"}, bus_if.dout, 0);
        check_val({tag, "_req"}, bus_if.mem_req, 0);
        check_val({tag, "_we"}, bus_if.mem_we, 0);
        check_val({tag, "_maddr"}, bus_if.mem_addr, 8'h00);
        check_val({tag, "_wdata"}, bus_if.mem_wdata, 0);
    endtask

    initial begin
        bus_if.start_save = 1'b0;
        bus_if.start_load = 1'b0;
        for (int i = 0; i < 256; i++) buffer[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");

        // Save with immediate ack
        push_save_exp();
        pulse_start(1'b1, 1'b0);
        wait_done("save", 400);
        check_val("save_cycles", done_cyc - busy_cyc, 135);
        check_val("save_busy_at_done", busy_at_done, 0);
        check_val("save_err", err_at_done, 0);
        check_val("save_buf8", buffer[8], 8'h5A);
        check_val("save_buf21", buffer[21], 8'h34);
        check_val("save_nrd", n_rd, 27);
        check_val("save_q_empty", exp_mw.size(), 0);

        // Load
        repeat (3) @(negedge clk);
        for (int i = 0; i < 27; i++) buffer[i] = 8'(i * 9 + 1);
        buffer[17] = 8'hA5;
        for (int i = 0; i < 27; i++) exp_cw.push_back({8'hC0, tb_addr[i], buffer[i]});
        pulse_start(1'b0, 1'b1);
        wait_done("load", 400);
        check_val("load_cycles", done_cyc - busy_cyc, 108);
        check_val("load_nwr", n_wr, 27);
        check_val("load_nrd", n_rd, 0);
        check_val("load_420c_count", n_420c, 1);
        check_val("load_420c_dout", dout_420c, 8'hA5);
        check_val("load_q_empty", exp_cw.size(), 0);

        // Responder does not claim $420F
        repeat (3) @(negedge clk);
        oe_kill = 16'h420F;
        push_save_exp();
        pulse_start(1'b1, 1'b0);
        wait_done("nooe", 400);
        check_val("nooe_buf19", buffer[19], 8'hFF);
        check_val("nooe_err", err_at_done, 1);
        check_val("nooe_nrd", n_rd, 27);
        check_val("nooe_q_empty", exp_mw.size(), 0);
        oe_kill = 16'h0000;

        // Buffer never acks
        repeat (3) @(negedge clk);
        ack_en = 1'b0;
        pulse_start(1'b1, 1'b0);
        #1;
        check_val("tmo_err_cleared", bus_if.err, 0);
        wait_done("tmo", 100);
        check_val("tmo_latency", done_cyc - req_cyc, 8);
        check_val("tmo_err", err_at_done, 1);
        check_val("tmo_busy", busy_at_done, 0);
        check_val("tmo_req_dropped", bus_if.mem_req, 0);
        ack_en = 1'b1;

        // Simultaneous starts, then a load request mid-save
        repeat (3) @(negedge clk);
        push_save_exp();
        pulse_start(1'b1, 1'b1);
        repeat (20) @(negedge clk);
        pulse_start(1'b0, 1'b1);
        wait_done("both", 400);
        check_val("both_we", req_we, 1);
        check_val("both_nwr", n_wr, 0);
        check_val("both_cycles", done_cyc - busy_cyc, 135);
        check_val("both_q_empty", exp_mw.size(), 0);

        // Reset during the strobe of entry 10
        repeat (3) @(negedge clk);
        push_save_exp();
        pulse_start(1'b1, 1'b0);
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                #1;
                hit = bus_if.cpurd_ce && (bus_if.ca == 24'hC04204);
            end
            check_val("rstmid_reached", hit, 1);
        end
        reset_n = 1'b0;
        #1;
        check_reset_vals("rstmid");
        repeat (2) @(negedge clk);
        check_reset_vals("rstmid_hold");
        reset_n = 1'b1;
        exp_mw.delete();
        repeat (2) @(negedge clk);
        push_save_exp();
        pulse_start(1'b1, 1'b0);
        wait_done("restart", 400);
        check_val("restart_first_ca", first_ca, 24'hC04300);
        check_val("restart_cycles", done_cyc - busy_cyc, 135);
        check_val("restart_q_empty", exp_mw.size(), 0);

        // Save with a two-cycle ack delay
        repeat (3) @(negedge clk);
        ack_delay = 2;
        for (int i = 0; i < 27; i++) buffer[i] = 8'h00;
        push_save_exp();
        pulse_start(1'b1, 1'b0);
        wait_done("slow", 500);
        check_val("slow_cycles", done_cyc - busy_cyc, 189);
        check_val("slow_err", err_at_done, 0);
        check_val("slow_buf8", buffer[8], 8'h5A);
        check_val("slow_q_empty", exp_mw.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
